branch_control_unit: RTL
========================

Name: branch_control_unit

Overview:
- Hardwired Moore/Mealy control FSM that sequences the CPU datapath: instruction fetch, decode, then execute for ldi, conditional branch (brzr/brnz/brpl/brmi), nop and halt.
- Drives the same control strobes the System datapath exposes, and replaces hand-sequenced bench stimulus.
- Reads IR opcode and con_ff_bit back from the datapath, and handshakes with the 512x32 memory via memory_done.

Parameters:
- DATA_WIDTH, 32, IR width.
- OP_LDI, 5'b00001, ldi opcode (IR[31:27]).
- OP_BR, 5'b10011, branch opcode; the condition is decoded by the datapath CON_FF from IR[22:19].
- OP_NOP, 5'b11010, nop opcode.
- OP_HALT, 5'b11011, halt opcode.
- ALU_ADD, 5'b00011, ALU add code.
- MEM_TIMEOUT, 16, max cycles to wait for memory_done.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- ir  in  DATA_WIDTH  current IR contents.
- con_ff_bit  in  1  branch condition flop from datapath.
- memory_done  in  1  memory read complete.
- PCout, MDRout, Zlo_out, Cout, BAout, Rout  out  1 each  bus drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin  out  1 each  register load strobes.
- Gra, Grb  out  1 each  register select.
- IncPC  out  1  ALU PC increment.
- opcode  out  5  ALU operation.
- Mem_Read, Mem_enable512x32  out  1 each  memory controls.
- HIout, LOout, Zhi_out, Inport_out, HIin, LOin, Grc, outport_in, Mem_Write  out  1 each  held 0 (reserved for later opcodes).
- run  out  1  high while not halted.
- illegal_op  out  1  sticky, unknown opcode seen.
- mem_fault  out  1  sticky, memory timeout.

Behaviour:
- States: RST, T0, T1, T2, T3, LDI4, LDI5, BR4, BR5, BR6, HALTED. One state per clock except T1 wait.
- clear high at a rising edge:
  - Next state is RST.
  - All outputs 0 that cycle, including Mem_enable512x32 mid-read.
  - illegal_op and mem_fault cleared; run = 0 in RST.
- RST: all strobes 0, run = 1 from the next cycle; RST -> T0.
- T0: PCout, IncPC, MARin, Zin = 1; opcode = ALU_ADD. T0 -> T1.
- T1:
  - Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32 = 1.
  - Stays in T1 until memory_done = 1, then -> T2. Repeated PCin is idempotent (Z unchanged).
  - Wait counter counts T1 cycles. If it reaches MEM_TIMEOUT without memory_done: -> HALTED, mem_fault = 1.
- T2: MDRout, IRin = 1. T2 -> T3.
- T3: outputs are Mealy on ir[31:27]; next state is set by opcode.
  - OP_LDI: Grb, BAout, Yin = 1 -> LDI4.
  - OP_BR: Gra, Rout, CONin = 1 -> BR4.
  - OP_NOP: no strobes -> T0.
  - OP_HALT: no strobes -> HALTED.
  - Any other opcode: no strobes, illegal_op = 1 -> HALTED.
- LDI4: Cout, Zin = 1, opcode = ALU_ADD -> LDI5.
- LDI5: Zlo_out, Gra, Rin = 1 -> T0.
- BR4: PCout, Yin = 1 -> BR5.
- BR5: Cout, Zin = 1, opcode = ALU_ADD -> BR6.
- BR6: Zlo_out = 1; PCin = con_ff_bit (combinational, CON_FF stable since T3) -> T0.
- HALTED: all strobes 0, run = 0; only clear exits.
- Instruction latency, counting cycles from T0, with memory_done in the first T1 cycle:
  - ldi: 6 cycles.
  - branch: 7 cycles.
  - nop: 4 cycles.
  - halt: 4 cycles, then HALTED.
- Strobe exclusivity: at most one bus driver (PCout, MDRout, Zlo_out, Cout, BAout/Rout pair) active in any cycle; verification asserts this.
- opcode output is 0 in every state other than T0, LDI4, BR5.

Test Plan:
- Reset: assert clear for 2 cycles in any state -> next cycle all outputs 0, state RST; the following cycle is T0 with PCout = IncPC = MARin = Zin = 1.
- ldi: memory returns 0x0A87FFFD (ldi r5,-3), memory_done set in the first T1 cycle -> 6-cycle strobe sequence T0..LDI5 exactly as specified; Gra/Rin pulse in LDI5; back to T0.
- brzr taken/not taken: ir = 0x9A800001, con_ff_bit = 1 -> PCin = 1 in BR6. Repeat with con_ff_bit = 0 -> PCin = 0 in BR6 and all other BR6 strobes unchanged.
- Memory wait: hold memory_done low for 3 cycles in T1 -> T1 strobes held 4 cycles, then T2. Hold low for 16 cycles -> HALTED, mem_fault = 1, run = 0, Mem_enable512x32 = 0.
- Halt/illegal: ir opcode 11011 -> HALTED, run = 0, illegal_op = 0. Opcode 11111 -> HALTED, illegal_op = 1. Assert clear -> both flags clear and execution restarts at T0.
- Reset mid-fetch: assert clear during T1 with Mem_Read high -> Mem_Read and Mem_enable512x32 are 0 on the next cycle; the FSM restarts from RST with no PCin pulse.

Source files
------------

// File: rtl/branch_control_unit_if.sv
// Control/status bundle between the branch control unit and the CPU datapath/memory.
// The master side is the control FSM; the slave side is the datapath that obeys the strobes.
interface branch_control_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ir;
  logic                  con_ff_bit;
  logic                  memory_done;

  logic PCout, MDRout, Zlo_out, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin;
  logic Gra, Grb, IncPC;
  logic [4:0] opcode;
  logic Mem_Read, Mem_enable512x32;
  logic HIout, LOout, Zhi_out, Inport_out, HIin, LOin, Grc, outport_in, Mem_Write;
  logic run, illegal_op, mem_fault;

  modport master (
    input  ir, con_ff_bit, memory_done,
    output PCout, MDRout, Zlo_out, Cout, BAout, Rout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin,
    output Gra, Grb, IncPC, opcode, Mem_Read, Mem_enable512x32,
    output HIout, LOout, Zhi_out, Inport_out, HIin, LOin, Grc, outport_in, Mem_Write,
    output run, illegal_op, mem_fault
  );

  modport slave (
    output ir, con_ff_bit, memory_done,
    input  PCout, MDRout, Zlo_out, Cout, BAout, Rout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin,
    input  Gra, Grb, IncPC, opcode, Mem_Read, Mem_enable512x32,
    input  HIout, LOout, Zhi_out, Inport_out, HIin, LOin, Grc, outport_in, Mem_Write,
    input  run, illegal_op, mem_fault
  );
endinterface

// File: rtl/branch_control_unit.sv
// Hardwired control FSM: fetch/decode, then ldi, conditional branch, nop and halt execution.
// Strobes decode from state (T3 and BR6 also look at ir / con_ff_bit); clear forces every output low.
module branch_control_unit #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [4:0] OP_LDI      = 5'b00001,
  parameter logic [4:0] OP_BR       = 5'b10011,
  parameter logic [4:0] OP_NOP      = 5'b11010,
  parameter logic [4:0] OP_HALT     = 5'b11011,
  parameter logic [4:0] ALU_ADD     = 5'b00011,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic                  Clock,
  input  logic                  clear,
  branch_control_unit_if.master bus
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_LDI4   = 4'd5;
  localparam logic [3:0] S_LDI5   = 4'd6;
  localparam logic [3:0] S_BR4    = 4'd7;
  localparam logic [3:0] S_BR5    = 4'd8;
  localparam logic [3:0] S_BR6    = 4'd9;
  localparam logic [3:0] S_HALTED = 4'd10;

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       pc_out, mdr_out, zlo_out, c_out, ba_out, r_out;
    logic       mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r_in, con_in;
    logic       gra, grb, inc_pc;
    logic [4:0] alu_op;
    logic       mem_read, mem_en;
  } ctrl_t;

  logic [3:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             illegal_r, fault_r;
  logic             illegal_set_s, fault_set_s;
  ctrl_t            ctrl_s, ctrl_out_s;
  logic             run_s, illegal_out_s, fault_out_s;
  logic [4:0]       op_s;
  logic [DATA_WIDTH-6:0] ir_unused_s;

  assign op_s        = bus.ir[DATA_WIDTH-1 -: 5];
  assign ir_unused_s = bus.ir[DATA_WIDTH-6:0];

  // Next-state and strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    ctrl_s        = '0;
    illegal_set_s = 1'b0;
    fault_set_s   = 1'b0;
    case (state_r)
      S_RST: state_nxt_s = S_T0;
      S_T0: begin
        ctrl_s.pc_out = 1'b1; ctrl_s.inc_pc = 1'b1; ctrl_s.mar_in = 1'b1; ctrl_s.z_in = 1'b1;
        ctrl_s.alu_op = ALU_ADD;
        state_nxt_s   = S_T1;
      end
      S_T1: begin
        ctrl_s.zlo_out = 1'b1; ctrl_s.pc_in = 1'b1; ctrl_s.mdr_in = 1'b1;
        ctrl_s.mem_read = 1'b1; ctrl_s.mem_en = 1'b1;
        if (bus.memory_done) begin
          state_nxt_s = S_T2;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_nxt_s = S_HALTED;
          fault_set_s = 1'b1;
        end else begin
          state_nxt_s = S_T1;
        end
      end
      S_T2: begin
        ctrl_s.mdr_out = 1'b1; ctrl_s.ir_in = 1'b1;
        state_nxt_s    = S_T3;
      end
      S_T3: begin
        case (op_s)
          OP_LDI: begin
            ctrl_s.grb = 1'b1; ctrl_s.ba_out = 1'b1; ctrl_s.y_in = 1'b1;
            state_nxt_s = S_LDI4;
          end
          OP_BR: begin
            ctrl_s.gra = 1'b1; ctrl_s.r_out = 1'b1; ctrl_s.con_in = 1'b1;
            state_nxt_s = S_BR4;
          end
          OP_NOP:  state_nxt_s = S_T0;
          OP_HALT: state_nxt_s = S_HALTED;
          default: begin
            illegal_set_s = 1'b1;
            state_nxt_s   = S_HALTED;
          end
        endcase
      end
      S_LDI4: begin
        ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1; ctrl_s.alu_op = ALU_ADD;
        state_nxt_s  = S_LDI5;
      end
      S_LDI5: begin
        ctrl_s.zlo_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.r_in = 1'b1;
        state_nxt_s    = S_T0;
      end
      S_BR4: begin
        ctrl_s.pc_out = 1'b1; ctrl_s.y_in = 1'b1;
        state_nxt_s   = S_BR5;
      end
      S_BR5: begin
        ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1; ctrl_s.alu_op = ALU_ADD;
        state_nxt_s  = S_BR6;
      end
      S_BR6: begin
        ctrl_s.zlo_out = 1'b1; ctrl_s.pc_in = bus.con_ff_bit;
        state_nxt_s    = S_T0;
      end
      S_HALTED: state_nxt_s = S_HALTED;
      default:  state_nxt_s = S_RST;
    endcase
  end

  // State, fetch wait counter and sticky fault flags.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_r    <= S_RST;
      wait_cnt_r <= '0;
      illegal_r  <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_T1) && (state_nxt_s == S_T1)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      illegal_r <= illegal_r | illegal_set_s;
      fault_r   <= fault_r | fault_set_s;
    end
  end

  // clear silences every output in the same cycle, including an in-flight memory read.
  always_comb begin
    if (clear) begin
      ctrl_out_s    = '0;
      run_s         = 1'b0;
      illegal_out_s = 1'b0;
      fault_out_s   = 1'b0;
    end else begin
      ctrl_out_s    = ctrl_s;
      run_s         = (state_r != S_RST) && (state_r != S_HALTED);
      illegal_out_s = illegal_r;
      fault_out_s   = fault_r;
    end
  end

  assign bus.PCout            = ctrl_out_s.pc_out;
  assign bus.MDRout           = ctrl_out_s.mdr_out;
  assign bus.Zlo_out          = ctrl_out_s.zlo_out;
  assign bus.Cout             = ctrl_out_s.c_out;
  assign bus.BAout            = ctrl_out_s.ba_out;
  assign bus.Rout             = ctrl_out_s.r_out;
  assign bus.MARin            = ctrl_out_s.mar_in;
  assign bus.Zin              = ctrl_out_s.z_in;
  assign bus.PCin             = ctrl_out_s.pc_in;
  assign bus.MDRin            = ctrl_out_s.mdr_in;
  assign bus.IRin             = ctrl_out_s.ir_in;
  assign bus.Yin              = ctrl_out_s.y_in;
  assign bus.Rin              = ctrl_out_s.r_in;
  assign bus.CONin            = ctrl_out_s.con_in;
  assign bus.Gra              = ctrl_out_s.gra;
  assign bus.Grb              = ctrl_out_s.grb;
  assign bus.IncPC            = ctrl_out_s.inc_pc;
  assign bus.opcode           = ctrl_out_s.alu_op;
  assign bus.Mem_Read         = ctrl_out_s.mem_read;
  assign bus.Mem_enable512x32 = ctrl_out_s.mem_en;
  assign bus.run              = run_s;
  assign bus.illegal_op       = illegal_out_s;
  assign bus.mem_fault        = fault_out_s;

  assign bus.HIout      = 1'b0;
  assign bus.LOout      = 1'b0;
  assign bus.Zhi_out    = 1'b0;
  assign bus.Inport_out = 1'b0;
  assign bus.HIin       = 1'b0;
  assign bus.LOin       = 1'b0;
  assign bus.Grc        = 1'b0;
  assign bus.outport_in = 1'b0;
  assign bus.Mem_Write  = 1'b0;

endmodule
